// File: rtl/decoder_index_sequencer_if.sv
// Control and index bus for decoder_index_sequencer: the master drives the
// control strobes, and the slave (the sequencer) returns code, step_pulse and wrap.
interface decoder_index_sequencer_if;
  logic       en;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] code;
  logic       step_pulse;
  logic       wrap;

  modport master (
    output en, dir, load, load_val,
    input  code, step_pulse, wrap
  );

  modport slave (
    input  en, dir, load, load_val,
    output code, step_pulse, wrap
  );
endinterface

// File: rtl/decoder_index_sequencer.sv
// 3-bit index sequencer stepped by a TICK_DIV prescaler, feeding a 3-to-8 decoder.
// Define BOUNCE_MODE_EN to get ping-pong sequencing from an UP/DOWN FSM in place of dir.
module decoder_index_sequencer #(
  parameter int unsigned TICK_DIV = 32'd25_000_000
) (
  input logic                        sys_clk,
  input logic                        sys_rst_n,
  decoder_index_sequencer_if.slave   bus
);

  localparam logic [31:0] LAST = 32'(TICK_DIV - 32'd1);

  logic [31:0] r_presc;
  logic [2:0]  r_code;
  logic        r_step;
  logic        r_wrap;

  logic        w_tick;
  logic [2:0]  w_code_next;
  logic        w_wrap_next;

`ifdef BOUNCE_MODE_EN
  typedef enum logic {ST_UP, ST_DOWN} state_t;
  state_t r_state;

  // Turn around at the end points instead of wrapping.
  always_comb begin
    w_code_next = r_code;
    w_wrap_next = 1'b0;
    if (r_state == ST_UP) begin
      w_code_next = (r_code == 3'd7) ? 3'd6 : r_code + 3'd1;
    end else begin
      w_code_next = (r_code == 3'd0) ? 3'd1 : r_code - 3'd1;
    end
  end
`else
  always_comb begin
    w_code_next = r_code;
    w_wrap_next = 1'b0;
    if (bus.dir) begin
      w_code_next = r_code + 3'd1;
      w_wrap_next = (r_code == 3'd7);
    end else begin
      w_code_next = r_code - 3'd1;
      w_wrap_next = (r_code == 3'd0);
    end
  end
`endif

  assign w_tick = bus.en && !bus.load && (r_presc == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc <= '0;
      r_code  <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef BOUNCE_MODE_EN
      r_state <= ST_UP;
`endif
    end else if (bus.load) begin
      r_presc <= '0;
      r_code  <= bus.load_val;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef BOUNCE_MODE_EN
      if (bus.load_val == 3'd7) begin
        r_state <= ST_DOWN;
      end else if (bus.load_val == 3'd0) begin
        r_state <= ST_UP;
      end
`endif
    end else if (bus.en) begin
      r_step <= w_tick;
      r_wrap <= w_tick && w_wrap_next;
      if (w_tick) begin
        r_presc <= '0;
        r_code  <= w_code_next;
`ifdef BOUNCE_MODE_EN
        if (r_state == ST_UP && r_code == 3'd7) begin
          r_state <= ST_DOWN;
        end else if (r_state == ST_DOWN && r_code == 3'd0) begin
          r_state <= ST_UP;
        end
`endif
      end else begin
        r_presc <= r_presc + 32'd1;
      end
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign bus.code       = r_code;
  assign bus.step_pulse = r_step;
  assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_decoder_index_sequencer.sv
// Bench for decoder_index_sequencer: DUT A uses TICK_DIV=4, DUT B uses TICK_DIV=1, both share stimulus.
// A reference model pushes the expected {code,step_pulse,wrap} each cycle; the value is popped after the edge.
module tb_decoder_index_sequencer;

  logic       clk;
  logic       rst_n;
  logic       t_en;
  logic       t_dir;
  logic       t_load;
  logic [2:0] t_lv;

  int unsigned checks;
  int unsigned errors;

  decoder_index_sequencer_if a_if ();
  decoder_index_sequencer_if b_if ();

  assign a_if.en = t_en;
  assign a_if.dir = t_dir;
  assign a_if.load = t_load;
  assign a_if.load_val = t_lv;
  assign b_if.en = t_en;
  assign b_if.dir = t_dir;
  assign b_if.load = t_load;
  assign b_if.load_val = t_lv;

  decoder_index_sequencer #(.TICK_DIV(4)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (a_if.slave)
  );

  decoder_index_sequencer #(.TICK_DIV(1)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] presc;
    logic [2:0]  code;
    logic        up;
    logic        step;
    logic        wrap;
  } mst_t;

  mst_t ma;
  mst_t mb;
  logic [9:0] sb_q[$];

  function automatic mst_t model_reset();
    mst_t r;
    r.presc = '0;
    r.code  = '0;
    r.up    = 1'b1;
    r.step  = 1'b0;
    r.wrap  = 1'b0;
    return r;
  endfunction

  function automatic mst_t model_next(mst_t s, int unsigned td, logic en, logic dir,
                                      logic ld, logic [2:0] lv);
    mst_t n;
    n = s;
    n.step = 1'b0;
    n.wrap = 1'b0;
    if (ld) begin
      n.code  = lv;
      n.presc = '0;
`ifdef BOUNCE_MODE_EN
      if (lv == 3'd7) n.up = 1'b0;
      else if (lv == 3'd0) n.up = 1'b1;
`endif
    end else if (en) begin
      if (s.presc == 32'(td - 1)) begin
        n.presc = '0;
        n.step  = 1'b1;
`ifdef BOUNCE_MODE_EN
        if (s.up) begin
          if (s.code == 3'd7) begin n.code = 3'd6; n.up = 1'b0; end
          else n.code = s.code + 3'd1;
        end else begin
          if (s.code == 3'd0) begin n.code = 3'd1; n.up = 1'b1; end
          else n.code = s.code - 3'd1;
        end
`else
        n.code = dir ? s.code + 3'd1 : s.code - 3'd1;
        n.wrap = dir ? (s.code == 3'd7) : (s.code == 3'd0);
`endif
      end else begin
        n.presc = s.presc + 32'd1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed {code,step,wrap}=%b_%b_%b expected %b_%b_%b",
             tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic [9:0] e;
    ma = model_next(ma, 4, t_en, t_dir, t_load, t_lv);
    mb = model_next(mb, 1, t_en, t_dir, t_load, t_lv);
    sb_q.push_back({ma.code, ma.step, ma.wrap, mb.code, mb.step, mb.wrap});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("dutA_cycle", {a_if.code, a_if.step_pulse, a_if.wrap}, e[9:5]);
    check("dutB_cycle", {b_if.code, b_if.step_pulse, b_if.wrap}, e[4:0]);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    t_en = 1'b0; t_dir = 1'b1; t_load = 1'b0; t_lv = 3'd0;
    rst_n = 1'b1;
    ma = model_reset();
    mb = model_reset();

    // Asynchronous reset before the first clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset_A", {a_if.code, a_if.step_pulse, a_if.wrap}, 5'b000_0_0);
    check("reset_B", {b_if.code, b_if.step_pulse, b_if.wrap}, 5'b000_0_0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up through the full range and the 7->0 wrap.
    t_en = 1'b1; t_dir = 1'b1;
    for (int i = 0; i < 34; i++) tick();

    // Count down through 0->7 and on to 6.
    t_dir = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Load collides with a step event of DUT A.
    t_dir = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ma.presc == 32'd3) begin found = 1'b1; break; end
      tick();
    end
    check("load_align_found", {4'd0, found}, 5'd1);
    t_load = 1'b1; t_lv = 3'd5;
    tick();
    check("load_on_step", {a_if.code, a_if.step_pulse, a_if.wrap}, 5'b101_0_0);
    t_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // en dropped for 10 cycles mid-period.
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ma.presc == 32'd2) begin found = 1'b1; break; end
      tick();
    end
    check("en_align_found", {4'd0, found}, 5'd1);
    t_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    t_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Load is effective while disabled.
    t_en = 1'b0; t_load = 1'b1; t_lv = 3'd5;
    tick();
    check("load_en0", {a_if.code, a_if.step_pulse, a_if.wrap}, 5'b101_0_0);
    t_load = 1'b0;
    tick();

    // Mixed random control traffic, including dir changes mid-period.
    for (int i = 0; i < 300; i++) begin
      t_en   = ($urandom_range(0, 3) != 0);
      t_dir  = 1'($urandom_range(0, 1));
      t_load = ($urandom_range(0, 15) == 0);
      t_lv   = 3'($urandom_range(0, 7));
      tick();
    end

    // Mid-period asynchronous reset with DUT A at code 3.
    t_en = 1'b1; t_dir = 1'b1; t_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (ma.code == 3'd3 && ma.presc == 32'd1) begin found = 1'b1; break; end
      tick();
    end
    check("rst_align_found", {4'd0, found}, 5'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_A", {a_if.code, a_if.step_pulse, a_if.wrap}, 5'b000_0_0);
    check("async_rst_B", {b_if.code, b_if.step_pulse, b_if.wrap}, 5'b000_0_0);
    ma = model_reset();
    mb = model_reset();
    @(negedge clk);
    check("rst_hold_A", {a_if.code, a_if.step_pulse, a_if.wrap}, 5'b000_0_0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
